// File: rtl/fb_write_arbiter_pkg.sv
// Shared types and helpers for the framebuffer write arbiter and its round-robin picker.
package fb_arb_pkg;

  typedef logic [23:0] rgb888_t;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Next index in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fb_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1, wrapping.
module rr_pick
  import fb_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int probe;
    logic [IW-1:0] p;
    pick  = '0;
    idx   = '0;
    any   = 1'b0;
    probe = int'(last);
    p     = last;
    for (int i = 0; i < N; i++) begin
      probe = rr_next(probe, N);
      p     = IW'(probe);
      if (!any && req[p]) begin
        any     = 1'b1;
        pick[p] = 1'b1;
        idx     = p;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin, burst-locking arbiter that shares the framebuffer write port among NREQ pixel producers.
// Handshake: a beat transfers on a cycle where req_valid_i[k] & req_ready_o[k]; ready never depends on valid.
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int ADDR_BITS = 14,
  parameter int PIXELS    = 14400,
  parameter int BURST_MAX = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [NREQ-1:0]           req_valid_i,
  input  logic [NREQ*ADDR_BITS-1:0] req_addr_i,
  input  logic [NREQ*24-1:0]        req_data_i,
  input  logic [NREQ-1:0]           req_last_i,
  output logic [NREQ-1:0]           req_ready_o,
  output logic [ADDR_BITS-1:0]      pxl_addr_o,
  output logic [23:0]               pxl_data_o,
  output logic                      pxl_en_o,
  output logic [NREQ-1:0]           grant_o,
  output logic [15:0]               drop_cnt_o,
  output logic                      state_o
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0]        BURST_END = BW'(BURST_MAX - 1);
  localparam logic [ADDR_BITS:0]   PIX_LIM   = (ADDR_BITS + 1)'(PIXELS);
  localparam logic [IW-1:0]        LAST_RST  = IW'(NREQ - 1);

  arb_state_e           state_q;
  logic [NREQ-1:0]      grant_q;
  logic [IW-1:0]        owner_q;
  logic [IW-1:0]        last_q;
  logic [BW-1:0]        burst_cnt_q;
  logic                 pxl_en_q;
  logic [ADDR_BITS-1:0] pxl_addr_q;
  rgb888_t              pxl_data_q;
  logic [15:0]          drop_q;

  logic [NREQ-1:0]      pick;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  logic                 sel_valid;
  logic                 sel_last;
  logic [ADDR_BITS-1:0] sel_addr;
  rgb888_t              sel_data;
  logic                 granted;
  logic                 accept;
  logic                 burst_done;
  logic                 in_range;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req  (req_valid_i),
    .last (last_q),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Owner's beat, selected by the registered owner index.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (owner_q == IW'(k)) begin
        sel_valid = req_valid_i[k];
        sel_last  = req_last_i[k];
        sel_addr  = req_addr_i[k*ADDR_BITS +: ADDR_BITS];
        sel_data  = req_data_i[k*24 +: 24];
      end
    end
  end

  assign granted     = (state_q == ARB_GRANT) && enable_i;
  assign req_ready_o = granted ? grant_q : '0;
  assign accept      = granted && sel_valid;
  assign burst_done  = sel_last || (burst_cnt_q == BURST_END);
  assign in_range    = {1'b0, sel_addr} < PIX_LIM;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      last_q      <= LAST_RST;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (enable_i && pick_any) begin
            state_q     <= ARB_GRANT;
            grant_q     <= pick;
            owner_q     <= pick_idx;
            burst_cnt_q <= '0;
          end
        end
        ARB_GRANT: begin
          if (accept) begin
            if (burst_done) begin
              state_q <= ARB_IDLE;
              grant_q <= '0;
              last_q  <= owner_q;
            end else begin
              burst_cnt_q <= burst_cnt_q + 1'b1;
            end
          end else if (enable_i) begin
            // Owner went quiet: it may not hold the port while idle.
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= owner_q;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Out-of-range beats complete their handshake but never reach the framebuffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pxl_en_q   <= 1'b0;
      pxl_addr_q <= '0;
      pxl_data_q <= '0;
      drop_q     <= '0;
    end else begin
      pxl_en_q <= 1'b0;
      if (accept) begin
        if (in_range) begin
          pxl_en_q   <= 1'b1;
          pxl_addr_q <= sel_addr;
          pxl_data_q <= sel_data;
        end else if (drop_q != 16'hFFFF) begin
          drop_q <= drop_q + 16'd1;
        end
      end
    end
  end

  assign pxl_en_o   = pxl_en_q;
  assign pxl_addr_o = pxl_addr_q;
  assign pxl_data_o = pxl_data_q;
  assign grant_o    = grant_q;
  assign drop_cnt_o = drop_q;
  assign state_o    = (state_q == ARB_GRANT);

endmodule
